// File: rtl/filter_ctrl.sv
// filter_ctrl: sequences sample-buffer writes, coefficient/sample reads and accumulator commands for a serial FIR.
package myfilter_pkg;
    localparam int DEF_NTAPS = 8;
    typedef enum logic [1:0] {ACC_NOP, ACC_LOAD, ACC_CLEAR} acc_cmd_t;
endpackage

module filter_ctrl
    import myfilter_pkg::*;
#(
    parameter int NTAPS = DEF_NTAPS,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic          smp_we,
    output logic          smp_wzero,
    output logic [AW-1:0] smp_waddr,
    output logic [AW-1:0] smp_raddr,
    output logic [AW-1:0] coef_addr,
    output acc_cmd_t      acc_cmd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, FLUSH, CLEAR, MAC, OUT} state_t;
    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] tap_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            tap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tap_cnt <= '0;
                    if (flush) state <= FLUSH;
                    else if (in_valid) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        state  <= CLEAR;
                    end
                end
                FLUSH: begin
                    tap_cnt <= tap_cnt + AW'(1);
                    if (tap_cnt == LAST) begin
                        wr_ptr <= '0;
                        state  <= IDLE;
                    end
                end
                CLEAR: begin
                    tap_cnt <= '0;
                    state   <= MAC;
                end
                MAC: begin
                    tap_cnt <= tap_cnt + AW'(1);
                    if (tap_cnt == LAST) state <= OUT;
                end
                OUT: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Address arithmetic is AW bits wide, so NTAPS being a power of two makes every wrap implicit.
    assign in_ready  = !rst && state == IDLE && !flush;
    assign smp_we    = !rst && ((state == IDLE && in_valid && !flush) || state == FLUSH);
    assign smp_wzero = !rst && state == FLUSH;
    assign smp_waddr = state == FLUSH ? tap_cnt : wr_ptr;
    assign smp_raddr = wr_ptr - AW'(1) - tap_cnt;
    assign coef_addr = tap_cnt;
    assign acc_cmd   = (rst || state == CLEAR) ? ACC_CLEAR : state == MAC ? ACC_LOAD : ACC_NOP;
    assign out_valid = !rst && state == OUT;
    assign busy      = !rst && state != IDLE;
endmodule

// File: tb/tb_filter_ctrl.sv
// tb_filter_ctrl: vector table, hand-written corner sequences and a software-FIR scoreboard for filter_ctrl.
module tb_filter_ctrl;
    import myfilter_pkg::*;
    localparam int N = 8;

    logic clk = 0, rst, in_valid, flush, out_ready;
    logic in_ready, smp_we, smp_wzero, out_valid, busy;
    logic [2:0] smp_waddr, smp_raddr, coef_addr;
    acc_cmd_t acc_cmd;
    logic signed [7:0] sample_data;
    logic signed [7:0] mem [N];
    logic signed [7:0] coef [N];
    int acc;
    int checks = 0, failures = 0;

    filter_ctrl #(.NTAPS(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .smp_we(smp_we), .smp_wzero(smp_wzero), .smp_waddr(smp_waddr), .smp_raddr(smp_raddr),
        .coef_addr(coef_addr), .acc_cmd(acc_cmd), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Sample buffer and accumulator the controller drives.
    always @(posedge clk) begin
        if (smp_we) mem[smp_waddr] <= smp_wzero ? 8'sd0 : sample_data;
        case (acc_cmd)
            ACC_CLEAR: acc <= 0;
            ACC_LOAD:  acc <= acc + int'(mem[smp_raddr]) * int'(coef[coef_addr]);
            default: ;
        endcase
    end

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] got %0d want %0d", nm, idx, act, exp);
        end
    endtask

    typedef struct {
        logic r, iv, fl, ordy;
        logic e_ir, e_we, e_wz;
        int e_wa, e_ra, e_ca;
        acc_cmd_t e_cmd;
        logic e_ov, e_bs;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t v(input logic r, iv, fl, ordy, ir, we, wz, input int wa, ra, ca,
                               input acc_cmd_t cmd, input logic ov, bs);
        vec_t x;
        x.r = r; x.iv = iv; x.fl = fl; x.ordy = ordy;
        x.e_ir = ir; x.e_we = we; x.e_wz = wz;
        x.e_wa = wa; x.e_ra = ra; x.e_ca = ca;
        x.e_cmd = cmd; x.e_ov = ov; x.e_bs = bs;
        return x;
    endfunction

    function automatic int fir(input int h[$]);
        int s = 0;
        for (int k = 0; k < h.size(); k++) s += int'(coef[k]) * h[k];
        return s;
    endfunction

    initial begin
        int hist[$], exp_q[$], t_q[$];
        int w, wexp, last_acc, n_acc;
        logic ov_prev;
        rst = 1; in_valid = 0; flush = 0; out_ready = 0; sample_data = 0;
        for (int k = 0; k < N; k++) coef[k] = 8'($urandom);

        // Single sample after reset, flush racing a sample, reset mid-MAC.
        tv.push_back(v(1,0,0,0, 0,0,0, 0,0,0, ACC_CLEAR,0,0));
        tv.push_back(v(1,0,0,0, 0,0,0, 0,0,0, ACC_CLEAR,0,0));
        tv.push_back(v(0,1,0,0, 1,1,0, 0,0,0, ACC_NOP,0,0));
        tv.push_back(v(0,0,0,0, 0,0,0, 0,0,0, ACC_CLEAR,0,1));
        for (int k = 0; k < N; k++) tv.push_back(v(0,1,0,0, 0,0,0, 0,(N-k)%N,k, ACC_LOAD,0,1));
        tv.push_back(v(0,1,0,0, 0,0,0, 0,0,0, ACC_NOP,1,1));
        tv.push_back(v(0,0,0,1, 0,0,0, 0,0,0, ACC_NOP,1,1));
        tv.push_back(v(0,0,0,0, 1,0,0, 0,0,0, ACC_NOP,0,0));
        tv.push_back(v(0,1,1,0, 0,0,0, 0,0,0, ACC_NOP,0,0));
        for (int k = 0; k < N; k++) tv.push_back(v(0,1,0,0, 0,1,1, k,0,0, ACC_NOP,0,1));
        tv.push_back(v(0,1,0,0, 1,1,0, 0,0,0, ACC_NOP,0,0));
        tv.push_back(v(0,0,0,0, 0,0,0, 0,0,0, ACC_CLEAR,0,1));
        for (int k = 0; k < 3; k++) tv.push_back(v(0,0,0,0, 0,0,0, 0,(N-k)%N,k, ACC_LOAD,0,1));
        tv.push_back(v(1,0,0,0, 0,0,0, 0,0,0, ACC_CLEAR,0,0));
        tv.push_back(v(0,0,0,0, 1,0,0, 0,0,0, ACC_NOP,0,0));
        tv.push_back(v(0,0,0,1, 1,0,0, 0,0,0, ACC_NOP,0,0));

        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].r; in_valid = tv[i].iv; flush = tv[i].fl; out_ready = tv[i].ordy;
            @(negedge clk);
            chk("in_ready", i, int'(in_ready), int'(tv[i].e_ir));
            chk("smp_we", i, int'(smp_we), int'(tv[i].e_we));
            chk("smp_wzero", i, int'(smp_wzero), int'(tv[i].e_wz));
            if (tv[i].e_we) chk("smp_waddr", i, int'(smp_waddr), tv[i].e_wa);
            if (tv[i].e_cmd == ACC_LOAD) begin
                chk("smp_raddr", i, int'(smp_raddr), tv[i].e_ra);
                chk("coef_addr", i, int'(coef_addr), tv[i].e_ca);
            end
            chk("acc_cmd", i, int'(acc_cmd), int'(tv[i].e_cmd));
            chk("out_valid", i, int'(out_valid), int'(tv[i].e_ov));
            chk("busy", i, int'(busy), int'(tv[i].e_bs));
            @(posedge clk); #1;
        end
        rst = 0; out_ready = 0;

        // Consumer stalls for 20 cycles in OUT.
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        w = 0;
        while (!out_valid && w < 30) begin @(posedge clk); #1; w++; end
        chk("ov_wait", 0, int'(out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            chk("stall_ov", i, int'(out_valid), 1);
            chk("stall_cmd", i, int'(acc_cmd), int'(ACC_NOP));
            chk("stall_ir", i, int'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("release_ov", 0, int'(out_valid), 1);
        @(posedge clk); #1;
        out_ready = 0;
        @(negedge clk);
        chk("release_ir", 0, int'(in_ready), 1);
        chk("release_busy", 0, int'(busy), 0);
        @(posedge clk); #1;

        // Scoreboard: clean history, a back-to-back burst, then random traffic with flushes.
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        w = 0;
        while (busy && w < 20) begin @(posedge clk); #1; w++; end
        chk("flush_done", 0, int'(busy), 0);
        wexp = 0; last_acc = -1; n_acc = 0; ov_prev = 0;
        for (int c = 0; c < 6000 && (n_acc < 60 || exp_q.size() > 0); c++) begin
            automatic logic burst = n_acc < 12;
            in_valid = n_acc < 60 && (burst || $urandom_range(0, 3) == 0);
            flush = !burst && n_acc < 60 && $urandom_range(0, 30) == 0;
            out_ready = burst || $urandom_range(0, 2) == 0;
            sample_data = 8'($urandom);
            @(negedge clk);
            if (flush && !busy) begin
                hist.delete();
                wexp = 0;
                chk("flush_ir", c, int'(in_ready), 0);
            end else if (in_valid && in_ready) begin
                chk("acc_waddr", c, int'(smp_waddr), wexp);
                wexp = (wexp + 1) % N;
                if (burst && last_acc >= 0) chk("period", c, c - last_acc, 11);
                last_acc = c;
                n_acc++;
                hist.push_front(int'(sample_data));
                if (hist.size() > N) void'(hist.pop_back());
                exp_q.push_back(fir(hist));
                t_q.push_back(c);
            end
            if (out_valid && !ov_prev) begin
                chk("spurious_out", c, int'(exp_q.size() > 0), 1);
                if (t_q.size() > 0) chk("latency", c, c - t_q[0], N + 2);
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                chk("fir_result", c, acc, exp_q.pop_front());
                void'(t_q.pop_front());
            end
            ov_prev = out_valid;
            @(posedge clk); #1;
        end
        chk("drained", 0, exp_q.size(), 0);
        chk("all_sent", 0, n_acc, 60);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
